// File: rtl/store_ctrl_pkg.sv
// Shared memory-stage types: scalar widths, access size encoding, byte masks.
package common;

  typedef logic [63:0] u64;
  typedef logic [7:0]  u8;
  typedef logic [2:0]  u3;

  typedef u8 strobe_t;

  // Access size. Encodings 4..7 are unused and are treated as illegal.
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  // Low-justified byte mask for an access size (zero for illegal sizes).
  function automatic strobe_t size_mask(input msize_t sz);
    strobe_t m;
    case (sz)
      MSIZE1:  m = 8'h01;
      MSIZE2:  m = 8'h03;
      MSIZE4:  m = 8'h0F;
      MSIZE8:  m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_ctrl_writedata.sv
// Combinational store lane placement: strobe, lane-aligned data, alignment check.
module writedata
  import common::*;
(
  input  u3       i_addr_lo,
  input  msize_t  i_size,
  input  u64      i_data,
  output strobe_t o_strobe,
  output u64      o_data,
  output logic    o_misalign
);

  u8            w_mask;
  logic [15:0]  w_strobe_wide;
  u64           w_byte_mask;

  // Mask, shifted strobe and byte-expanded data placement.
  always_comb begin
    w_mask        = size_mask(i_size);
    w_strobe_wide = {8'h00, w_mask} << i_addr_lo;
    for (int b = 0; b < 8; b++) begin
      w_byte_mask[b*8 +: 8] = {8{w_mask[b]}};
    end
    o_strobe = w_strobe_wide[7:0];
    o_data   = (i_data & w_byte_mask) << {i_addr_lo, 3'b000};
  end

  // Natural alignment; illegal sizes always abort.
  always_comb begin
    case (i_size)
      MSIZE1:  o_misalign = 1'b0;
      MSIZE2:  o_misalign = i_addr_lo[0];
      MSIZE4:  o_misalign = |i_addr_lo[1:0];
      MSIZE8:  o_misalign = |i_addr_lo;
      default: o_misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_ctrl.sv
// Memory-stage store controller: lane placement, alignment abort, held dbus write.
module store_ctrl
  import common::*;
(
  input  logic    clk,
  input  logic    resetn,
  input  logic    st_valid,
  input  u64      st_addr,
  input  u64      st_data,
  input  msize_t  st_msize,
  output logic    st_ready,
  output logic    st_done,
  output logic    st_misalign,
  output logic    dreq_valid,
  output u64      dreq_addr,
  output msize_t  dreq_size,
  output strobe_t dreq_strobe,
  output u64      dreq_data,
  input  logic    dresp_data_ok
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t  r_state, w_next;
  logic    w_accept, w_abort, w_ack;
  strobe_t w_strobe;
  u64      w_data;
  logic    w_misalign;

  logic    r_done, r_misalign, r_dreq_valid;
  u64      r_addr, r_data;
  msize_t  r_size;
  strobe_t r_strobe;

  writedata u_wd (
    .i_addr_lo  (st_addr[2:0]),
    .i_size     (st_msize),
    .i_data     (st_data),
    .o_strobe   (w_strobe),
    .o_data     (w_data),
    .o_misalign (w_misalign)
  );

  // Next-state and handshake decode; requests while busy are simply not accepted.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_abort  = 1'b0;
    w_ack    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (st_valid) begin
          if (w_misalign) begin
            w_abort = 1'b1;
          end else begin
            w_accept = 1'b1;
            w_next   = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (dresp_data_ok) begin
          w_ack  = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Completion pulses and request-valid flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_done       <= 1'b0;
      r_misalign   <= 1'b0;
      r_dreq_valid <= 1'b0;
    end else begin
      r_done     <= w_ack | w_abort;
      r_misalign <= w_abort;
      if (w_accept)   r_dreq_valid <= 1'b1;
      else if (w_ack) r_dreq_valid <= 1'b0;
    end
  end

  // Request fields are captured on accept and held until the next accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr   <= '0;
      r_data   <= '0;
      r_size   <= MSIZE1;
      r_strobe <= 8'h00;
    end else if (w_accept) begin
      r_addr   <= st_addr;
      r_data   <= w_data;
      r_size   <= st_msize;
      r_strobe <= w_strobe;
    end
  end

  assign st_ready    = (r_state == S_IDLE);
  assign st_done     = r_done;
  assign st_misalign = r_misalign;
  assign dreq_valid  = r_dreq_valid;
  assign dreq_addr   = r_addr;
  assign dreq_size   = r_size;
  assign dreq_strobe = r_strobe;
  assign dreq_data   = r_data;

endmodule

// File: doc/store_ctrl.md
# store_ctrl

Memory-stage store controller for the 64-bit pipeline. It is the write-side counterpart to load-data extraction: it places the `rs2` value into the correct byte lanes of a 64-bit data-bus word and generates the byte strobe. It also checks natural alignment and holds a registered `dbus` write request until the bus acknowledges it. Sits between the memory-stage pipeline register and the data-bus arbiter.

## Interface
- No parameters; widths fixed by `common` (u64, u8, u3, msize_t).
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `st_valid` in 1: store request from pipeline; accepted only when `st_ready`=1.
- `st_addr` in 64: byte address of store.
- `st_data` in 64: unaligned source data (`rs2`); low 1/2/4/8 bytes used.
- `st_msize` in msize_t: MSIZE1/2/4/8.
- `st_ready` out 1: controller idle, can accept.
- `st_done` out 1: one-cycle pulse, store finished (bus ack or misalign abort).
- `st_misalign` out 1: one-cycle pulse with `st_done` when the store was rejected as misaligned.
- `dreq_valid` out 1: bus write request valid.
- `dreq_addr` out 64: captured `st_addr`, unmodified.
- `dreq_size` out msize_t: captured size.
- `dreq_strobe` out 8: byte-lane write enables.
- `dreq_data` out 64: lane-aligned write data.
- `dresp_data_ok` in 1: bus completion for the outstanding request.

## Operation
- States: IDLE, BUSY. `st_ready` = (state==IDLE).
- Lane offset `o` = `st_addr[2:0]`. Mask is 8'h01/8'h03/8'h0F/8'hFF for MSIZE1/2/4/8.
  - strobe = mask << o, truncated to 8 bits.
  - data = (`st_data` & byte-expanded mask) << (8·o).
  - Unused lanes are zero.
- Misaligned when any of these holds:
  - MSIZE2 and `o[0]`≠0
  - MSIZE4 and `o[1:0]`≠0
  - MSIZE8 and `o`≠0
  - MSIZE1 is never misaligned.
- IDLE, `st_valid`=1, aligned: register addr/size/strobe/data; next state BUSY.
- IDLE, `st_valid`=1, misaligned: no bus request. Next cycle `st_done`=1 and `st_misalign`=1; stay IDLE.
- BUSY: `dreq_valid`=1 with all `dreq_*` fields held constant. On `dresp_data_ok`=1, go to IDLE; next cycle `dreq_valid`=0 and `st_done`=1.
- `st_valid` while BUSY: ignored, not queued; pipeline must hold it.
- `dresp_data_ok` while IDLE: ignored.
- Unknown `st_msize`: treated as misaligned (abort with `st_misalign`).

## Timing
- Reset (async assert, any state):
  - state IDLE
  - `dreq_valid`, `st_done`, `st_misalign` = 0
  - `dreq_addr`/`dreq_data` = 0, `dreq_strobe` = 8'h00, `dreq_size` = MSIZE1
- Reset during BUSY drops `dreq_valid` immediately, with no `st_done`.
- All outputs except `st_ready` are registered; `st_ready` is decoded from the state register.
- Accept at edge N: `dreq_valid`=1 from cycle N+1.
- `dresp_data_ok` sampled high at edge M (M ≥ N+1, same cycle allowed as first valid cycle): `dreq_valid`=0 and `st_done`=1 in cycle M+1; `st_ready`=1 in cycle M+1.
- Minimum store occupancy: accept cycle plus one bus cycle plus a done cycle.
- A new `st_valid` may be accepted in the `st_done` cycle (back-to-back). That request's `dreq_valid` rises in the following cycle, so there is one-cycle bubble on the bus between stores.
- Misaligned: `st_done`/`st_misalign` pulse in cycle N+1; `st_ready` stays 1 throughout.

## Structure
- `common` package holds:
  - msize_t encodings
  - `strobe_t` (u8)
  - a function `size_mask(msize_t)` returning the 8-bit mask; the load side uses the same function.
- Sub-module `writedata` (combinational) computes aligned data, strobe and misalign flag from addr[2:0], size and data. `store_ctrl` instantiates it and owns the FSM and registers.

## Test plan
- MSIZE1, addr=...0x5, data=0xAB: `dreq_strobe`=8'h20, `dreq_data`=0x0000_AB00_0000_0000. `dresp_data_ok` asserted 3 cycles later -> `st_done` pulses exactly once, 1 cycle after ack.
- MSIZE4, addr=...0x4, data=0xFFFF_FFFF_1234_5678: strobe=8'hF0, data=0x1234_5678_0000_0000. Fields are stable across a 5-cycle ack wait.
- MSIZE2 addr=...0x3 and MSIZE8 addr=...0x4: no `dreq_valid` ever; `st_done`=`st_misalign`=1 for one cycle at N+1.
- Back-to-back MSIZE8 addr=...0x0 stores with zero-wait ack: second accepted in the `st_done` cycle, and `dreq_valid` pattern is 1,0,1.
- `st_valid` held while BUSY, and `dresp_data_ok` pulsed in IDLE: no extra request, no spurious `st_done`.
- `resetn` low mid-BUSY: `dreq_valid`=0 immediately, no `st_done`. After release `st_ready`=1 and all outputs are at reset values.
